// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative multiply/divide
// into architectural HI/LO, handshaked through an IDLE/BUSY/DONE FSM.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [3:0]       i_control,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zf,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULT  = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_MFLO  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zf;
    logic             r_valid;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_signed;
    logic [WIDTH-1:0] w_op1_mag;
    logic [WIDTH-1:0] w_op2_mag;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH:0]   w_madd;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic [WIDTH-1:0] w_hi_nx;
    logic [WIDTH-1:0] w_lo_nx;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_hi_fin;
    logic [WIDTH-1:0] w_lo_fin;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic sgn);
        if (sgn && x[WIDTH-1]) begin
            return -x;
        end else begin
            return x;
        end
    endfunction

    function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] c, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] hi,
                                                input logic [WIDTH-1:0] lo);
        case (c)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: return {{(WIDTH-1){1'b0}}, (a < b)};
            OP_NOR:  return ~(a | b);
            OP_MFHI: return hi;
            OP_MFLO: return lo;
            default: return {WIDTH{1'b0}};
        endcase
    endfunction

    // Operand decode, one multiply/divide iteration, and sign fix-up of the final step.
    always_comb begin
        w_accept  = i_valid && (r_state == S_IDLE);
        w_is_mul  = (i_control == OP_MULT) || (i_control == OP_MULTU);
        w_is_div  = (i_control == OP_DIV) || (i_control == OP_DIVU);
        w_signed  = (i_control == OP_MULT) || (i_control == OP_DIV);
        w_op1_mag = abs_val(i_op1, w_signed);
        w_op2_mag = abs_val(i_op2, w_signed);
        w_alu     = alu_op(i_control, i_op1, i_op2, r_hi, r_lo);

        w_madd  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_dvs} : {(WIDTH+1){1'b0}});
        w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_diff  = {1'b0, w_shift} - {2'b00, r_dvs};

        if (r_is_div) begin
            // Restoring step: keep the trial difference only when it did not borrow.
            if (w_diff[WIDTH+1]) begin
                w_hi_nx = w_shift[WIDTH-1:0];
                w_lo_nx = {r_acc_lo[WIDTH-2:0], 1'b0};
            end else begin
                w_hi_nx = w_diff[WIDTH-1:0];
                w_lo_nx = {r_acc_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            w_hi_nx = w_madd[WIDTH:1];
            w_lo_nx = {w_madd[0], r_acc_lo[WIDTH-1:1]};
        end

        w_prod = {w_hi_nx, w_lo_nx};
        if (r_is_div) begin
            // Divide by zero leaves the dividend magnitude as remainder, so the
            // sign fix-up restores op1 in HI; only LO needs forcing.
            w_hi_fin = r_neg_r ? -w_hi_nx : w_hi_nx;
            if (r_div0) begin
                w_lo_fin = {WIDTH{1'b1}};
            end else begin
                w_lo_fin = r_neg_q ? -w_lo_nx : w_lo_nx;
            end
        end else begin
            if (r_neg_q) begin
                w_prod = -w_prod;
            end else begin
                w_prod = w_prod;
            end
            w_hi_fin = w_prod[2*WIDTH-1:WIDTH];
            w_lo_fin = w_prod[WIDTH-1:0];
        end
    end

    // Control FSM with all architectural and datapath state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_result <= {WIDTH{1'b0}};
            r_zf     <= 1'b1;
            r_valid  <= 1'b0;
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
            r_acc_hi <= {WIDTH{1'b0}};
            r_acc_lo <= {WIDTH{1'b0}};
            r_dvs    <= {WIDTH{1'b0}};
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (w_accept) begin
                        if (w_is_mul || w_is_div) begin
                            r_state  <= S_BUSY;
                            r_cnt    <= CW'(WIDTH - 1);
                            r_acc_hi <= {WIDTH{1'b0}};
                            r_acc_lo <= w_is_div ? w_op1_mag : w_op2_mag;
                            r_dvs    <= w_is_div ? w_op2_mag : w_op1_mag;
                            r_is_div <= w_is_div;
                            r_neg_q  <= w_signed && (i_op1[WIDTH-1] ^ i_op2[WIDTH-1]);
                            r_neg_r  <= w_signed && i_op1[WIDTH-1];
                            r_div0   <= (i_op2 == {WIDTH{1'b0}});
                        end else begin
                            r_state  <= S_DONE;
                            r_result <= w_alu;
                            r_zf     <= (w_alu == {WIDTH{1'b0}});
                            r_valid  <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    r_acc_hi <= w_hi_nx;
                    r_acc_lo <= w_lo_nx;
                    if (r_cnt == {CW{1'b0}}) begin
                        r_state <= S_DONE;
                        r_hi    <= w_hi_fin;
                        r_lo    <= w_lo_fin;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready  = (r_state == S_IDLE);
    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_zf     = r_zf;
    assign o_hi     = r_hi;
    assign o_lo     = r_lo;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): table of single-cycle vectors plus
// hand-written mul/div, back-to-back and reset-abort sequences.
module tb_seq_alu;
    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic [3:0]  i_control;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_zf;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_res;
    logic        last_zf;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zf;
    } vec_t;

    vec_t vecs[15];

    seq_alu #(.WIDTH(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_control(i_control),
        .i_op1(i_op1), .i_op2(i_op2), .o_ready(o_ready), .o_valid(o_valid),
        .o_result(o_result), .o_zf(o_zf), .o_hi(o_hi), .o_lo(o_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int t;
        t = 0;
        while (!o_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_issue", {63'd0, o_ready}, 64'd1);
        i_control = c;
        i_op1 = a;
        i_op2 = b;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Counts negedges after the accept until o_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_valid && lat < 100);
        if (!o_valid) chk("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_end(input string name);
        @(negedge clk);
        chk(name, {63'd0, o_valid}, 64'd0);
    endtask

    task automatic run_md(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        issue(c, a, b);
        wait_valid(lat);
        chk({name, "_lat"}, 64'(lat), 64'd33);
        chk({name, "_hi"}, {32'd0, o_hi}, {32'd0, ehi});
        chk({name, "_lo"}, {32'd0, o_lo}, {32'd0, elo});
        chk({name, "_res_kept"}, {31'd0, o_zf, o_result}, {31'd0, last_zf, last_res});
        pulse_end({name, "_pulse"});
    endtask

    task automatic run_single(input string name, input logic [3:0] c, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] er, input logic ez);
        int lat;
        issue(c, a, b);
        wait_valid(lat);
        chk({name, "_lat"}, 64'(lat), 64'd1);
        chk({name, "_res"}, {32'd0, o_result}, {32'd0, er});
        chk({name, "_zf"}, {63'd0, o_zf}, {63'd0, ez});
        last_res = er;
        last_zf = ez;
        pulse_end({name, "_pulse"});
    endtask

    initial begin
        int pulses;
        int lat;
        vecs[0]  = '{"mfhi_rst",   4'b1110, 32'h1234_5678, 32'h1,         32'h0,         1'b1};
        vecs[1]  = '{"add_wrap",   4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1};
        vecs[2]  = '{"and",        4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0};
        vecs[3]  = '{"or",         4'b0001, 32'h1200_0034, 32'h0000_5600, 32'h1200_5634, 1'b0};
        vecs[4]  = '{"sub_neg",    4'b0110, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0};
        vecs[5]  = '{"slt",        4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0};
        vecs[6]  = '{"sltu",       4'b1000, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1};
        vecs[7]  = '{"code0011",   4'b0011, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0,         1'b1};
        vecs[8]  = '{"nor_zero",   4'b1100, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{"nor",        4'b1100, 32'hF0F0_0000, 32'h0F0F_0000, 32'h0000_FFFF, 1'b0};
        vecs[10] = '{"code0100",   4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[11] = '{"add_ovf",    4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0};
        vecs[12] = '{"slt_pos",    4'b0111, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[13] = '{"slt_min",    4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1,         1'b0};
        vecs[14] = '{"sub_under",  4'b0110, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0};

        rst_n = 1'b0;
        i_valid = 1'b0;
        i_control = 4'b0;
        i_op1 = 32'd0;
        i_op2 = 32'd0;
        last_res = 32'd0;
        last_zf = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_state", {28'd0, o_ready, o_valid, o_zf, 1'b0, o_result},
            {28'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0});
        chk("rst_hilo", {o_hi, o_lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run_single(vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zf);
        end

        // MULT with ignored requests while busy.
        issue(4'b1001, 32'hFFFF_FFFD, 32'd5);
        i_control = 4'b0010;
        i_op1 = 32'd1;
        i_op2 = 32'd1;
        i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("busy_not_ready", {63'd0, o_ready}, 64'd0);
        end
        i_valid = 1'b0;
        lat = 5;
        while (!o_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("mult_lat", 64'(lat), 64'd33);
        chk("mult_hilo", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        chk("mult_res_kept", {31'd0, o_zf, o_result}, {31'd0, last_zf, last_res});
        pulse_end("mult_pulse");
        chk("busy_req_dropped", {63'd0, o_ready}, 64'd1);

        run_md("multu_max", 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_md("div_neg",   4'b1011, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div_negd",  4'b1011, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
        run_md("divu",      4'b1101, 32'd100,       32'd7,         32'd2,         32'd14);
        run_md("divu_zero", 4'b1101, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF);
        run_single("mflo", 4'b1111, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_single("mfhi", 4'b1110, 32'd0, 32'd0, 32'd7, 1'b0);
        run_md("div_szero", 4'b1011, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_md("div_ovf",   4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);

        // Back-to-back single-cycle issue: one accept every two cycles.
        i_control = 4'b0010;
        i_op1 = 32'd1;
        i_op2 = 32'd2;
        i_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("b2b_valid", {63'd0, o_valid}, (k % 2 == 0) ? 64'd1 : 64'd0);
        end
        i_valid = 1'b0;
        chk("b2b_res", {32'd0, o_result}, 64'd3);
        last_res = 32'd3;
        last_zf = 1'b0;

        // Reset in the middle of a MULTU.
        issue(4'b1010, 32'd12345, 32'd678);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ready", {63'd0, o_ready}, 64'd1);
        chk("abort_hilo", {o_hi, o_lo}, 64'd0);
        chk("abort_res", {31'd0, o_zf, o_result}, {31'd0, 1'b1, 32'd0});
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_valid) pulses++;
        end
        chk("abort_no_valid", 64'(pulses), 64'd0);
        chk("abort_hilo_late", {o_hi, o_lo}, 64'd0);
        run_single("add_after_rst", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
